unpack_frame: RTL and testbench

Receive-side frame synchroniser and byte packer, sitting directly downstream of `Pack`. It consumes the serial 1-bit stream that `Pack` emits under a valid/ready handshake and hunts for the 32-bit preamble `CF80AA31`. On lock it regroups the following payload bits MSB-first into bytes and delivers them with a valid/ready handshake, flagging the last byte of each frame.

---
 rtl/pack_pkg.sv | 16 +
 rtl/unpack_frame_preamble_detect.sv | 53 +++++
 rtl/unpack_frame.sv | 138 +++++++++++++
 tb/tb_unpack_frame.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pack_pkg.sv
// Shared constants and types for the Pack / unpack_frame serial link.
// Frame = 32-bit preamble followed by 243 payload bytes, MSB-first on the wire.
// Both ends import this package so frame geometry cannot drift apart.
package pack_pkg;

  localparam int unsigned SIZE_BIT_PACK        = 1976;
  localparam int unsigned SISE_PREAMBLE        = 32;
  localparam logic [31:0] PREAMBLE             = 32'hCF80AA31;
  localparam int unsigned LENGTHE_PAYLOAD_BYTE = (SIZE_BIT_PACK - SISE_PREAMBLE) / 8;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } unpack_state_t;

endpackage

// File: rtl/unpack_frame_preamble_detect.sv
// Sliding-window preamble detector with bounded bit-error tolerance.
// Latency: o_match is combinational on the bit being shifted in this cycle.
// Backpressure: none; advances only when i_shift is asserted by the parent.
module preamble_detect #(
  parameter int unsigned         PRE_W   = 32,
  parameter logic [PRE_W-1:0]    PATTERN = 32'hCF80AA31,
  parameter int unsigned         MAX_ERR = 0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_shift,
  input  logic i_clr,
  input  logic i_bit,
  output logic o_match
);

  localparam int unsigned  CW   = $clog2(PRE_W + 1);
  localparam logic [CW-1:0] FULL = CW'(PRE_W);

  logic [PRE_W-1:0] pre_sr_q, pre_sr_d;
  logic [CW-1:0]    pre_cnt_q, pre_cnt_d;

  // Next window contents and saturating fill count; clear wipes stale bits.
  always_comb begin
    pre_sr_d  = pre_sr_q;
    pre_cnt_d = pre_cnt_q;
    if (i_clr) begin
      pre_sr_d  = '0;
      pre_cnt_d = '0;
    end else if (i_shift) begin
      pre_sr_d  = {pre_sr_q[PRE_W-2:0], i_bit};
      pre_cnt_d = (pre_cnt_q == FULL) ? FULL : pre_cnt_q + 1'b1;
    end
  end

  // Match is judged on the window that includes the bit arriving now.
  always_comb begin
    o_match = i_shift && !i_clr && (pre_cnt_d == FULL) &&
              ($countones(pre_sr_d ^ PATTERN) <= int'(MAX_ERR));
  end

  // Window and fill-count registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pre_sr_q  <= '0;
      pre_cnt_q <= '0;
    end else begin
      pre_sr_q  <= pre_sr_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/unpack_frame.sv
// Frame synchroniser + byte packer: hunts for the preamble, then packs payload bits MSB-first into bytes.
// Latency: lock visible 1 cycle after the last preamble bit; byte valid 1 cycle after its 8th bit.
// Backpressure: bit input stalls only when a finished byte would overwrite an undrained output byte.
module unpack_frame #(
  parameter int unsigned                      SIZE_BIT_PACK   = pack_pkg::SIZE_BIT_PACK,
  parameter int unsigned                      SISE_PREAMBLE   = pack_pkg::SISE_PREAMBLE,
  parameter logic [SISE_PREAMBLE-1:0]         PREAMBLE        = pack_pkg::PREAMBLE,
  parameter int unsigned                      SIZE_OUTPUT_BIT = 8,
  parameter int unsigned                      MAX_ERR         = 0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_data,
  input  logic                       i_valid_input,
  output logic                       o_ready_input,
  output logic [SIZE_OUTPUT_BIT-1:0] o_data,
  output logic                       o_valid,
  input  logic                       i_ready_output,
  output logic                       o_last,
  output logic                       o_locked
);

  import pack_pkg::*;

  localparam int unsigned   W         = SIZE_OUTPUT_BIT;
  localparam int unsigned   LEN       = (SIZE_BIT_PACK - SISE_PREAMBLE) / W;
  localparam int unsigned   BW        = $clog2(W);
  localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
  localparam logic [7:0]    BYTE_LAST = 8'(LEN - 1);

  unpack_state_t state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [W-2:0]  asm_q, asm_d;
  logic [W-1:0]  dat_q, dat_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;

  logic accept, xfer, drain, frame_end, match;

  assign accept    = i_valid_input && o_ready_input;
  assign xfer      = (state_q == PAYLOAD) && accept && (bit_cnt_q == BIT_LAST);
  assign drain     = vld_q && i_ready_output;
  assign frame_end = xfer && (byte_cnt_q == BYTE_LAST);

  preamble_detect #(
    .PRE_W   (SISE_PREAMBLE),
    .PATTERN (PREAMBLE),
    .MAX_ERR (MAX_ERR)
  ) u_detect (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_shift ((state_q == HUNT) && accept),
    .i_clr   (frame_end),
    .i_bit   (i_data),
    .o_match (match)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= HUNT;
    else          state_q <= state_d;
  end

  // FSM next state: lock on match, release after the final payload byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (match)     state_d = PAYLOAD;
      PAYLOAD: if (frame_end) state_d = HUNT;
      default:                state_d = HUNT;
    endcase
  end

  // FSM outputs: stall only when the completing bit has nowhere to go.
  always_comb begin
    o_locked      = (state_q == PAYLOAD);
    o_ready_input = !((state_q == PAYLOAD) && (bit_cnt_q == BIT_LAST) &&
                      vld_q && !i_ready_output);
  end

  // Byte assembly and frame counters.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    if (state_q == HUNT) begin
      if (match) begin
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
      end
    end else if (accept) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      asm_d     = {asm_q[W-3:0], i_data};
      if (xfer) byte_cnt_d = byte_cnt_q + 1'b1;
    end
  end

  // Output register: a new byte wins over a same-cycle drain so valid stays high.
  always_comb begin
    dat_d  = dat_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (xfer) begin
      dat_d  = {asm_q, i_data};
      vld_d  = 1'b1;
      last_d = (byte_cnt_q == BYTE_LAST);
    end else if (drain) begin
      dat_d  = '0;
      vld_d  = 1'b0;
      last_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      dat_q      <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      dat_q      <= dat_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
    end
  end

  assign o_data  = dat_q;
  assign o_valid = vld_q;
  assign o_last  = last_q;

endmodule

// File: tb/tb_unpack_frame.sv
// Directed bench for unpack_frame: lock timing, error tolerance, embedded preamble,
// output backpressure, mid-frame reset and back-to-back frames.
module tb_unpack_frame;

  localparam int NB = 243;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic vin = 1'b0;
  logic rdy_out = 1'b1;

  logic       rdy0, vld0, last0, lock0;
  logic [7:0] dat0;
  logic       rdy1, vld1, last1, lock1;
  logic [7:0] dat1;

  int total = 0;
  int bad = 0;

  logic [31:0] pre = 32'hCF80AA31;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_dat[$];
  logic        rx_last[$];

  unpack_frame #(.MAX_ERR(0)) dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_data(din), .i_valid_input(vin),
    .o_ready_input(rdy0), .o_data(dat0), .o_valid(vld0),
    .i_ready_output(rdy_out), .o_last(last0), .o_locked(lock0)
  );

  unpack_frame #(.MAX_ERR(1)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_data(din), .i_valid_input(vin),
    .o_ready_input(rdy1), .o_data(dat1), .o_valid(vld1),
    .i_ready_output(rdy_out), .o_last(last1), .o_locked(lock1)
  );

  always #5 clk = ~clk;

  // Record every byte that drains from dut0 at the next rising edge.
  always @(negedge clk) begin
    if (vld0 && rdy_out) begin
      rx_dat.push_back(dat0);
      rx_last.push_back(last0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    int waited;
    waited = 0;
    din = b;
    vin = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy0) break;
      waited++;
      if (waited > 200) begin
        total++;
        bad++;
        $error("FAIL send_timeout observed=stalled expected=accepted");
        vin = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    vin = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame(input int base);
    send_word(pre, 32);
    for (int i = 0; i < NB; i++) send_word(32'(exp_q[base + i]), 8);
  endtask

  task automatic send_pbit(input int k);
    logic [7:0] b;
    b = exp_q[k / 8];
    send_bit(b[7 - (k % 8)]);
  endtask

  task automatic build_payload(input int seed);
    for (int i = 0; i < NB; i++) exp_q.push_back(8'((i * 29 + seed * 53 + 3) % 256));
  endtask

  task automatic wait_drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_rx(input string tag, input int nframes);
    int nbytes;
    int mism;
    int lbad;
    nbytes = nframes * NB;
    mism = 0;
    lbad = 0;
    check($sformatf("%s_count", tag), 32'(rx_dat.size()), 32'(nbytes));
    if (rx_dat.size() == nbytes) begin
      for (int i = 0; i < nbytes; i++) begin
        if (rx_dat[i] !== exp_q[i]) mism++;
        if (rx_last[i] !== ((i % NB) == NB - 1)) lbad++;
      end
    end
    check($sformatf("%s_bytes", tag), 32'(mism), 32'd0);
    check($sformatf("%s_last_pos", tag), 32'(lbad), 32'd0);
  endtask

  initial begin
    logic [31:0] flipped;
    int n;
    logic found;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(vld0), 32'd0);
    check("rst_last", 32'(last0), 32'd0);
    check("rst_data", 32'(dat0), 32'd0);
    check("rst_locked", 32'(lock0), 32'd0);
    check("rst_ready", 32'(rdy0), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame with lock timing.
    exp_q.delete();
    build_payload(1);
    rx_dat.delete();
    rx_last.delete();
    send_word(pre >> 1, 31);
    check("lock_early", 32'(lock0), 32'd0);
    send_bit(pre[0]);
    check("lock_latency", 32'(lock0), 32'd1);
    for (int i = 0; i < NB; i++) send_word(32'(exp_q[i]), 8);
    check("f1_unlock", 32'(lock0), 32'd0);
    check("f1_last_vld", 32'(vld0), 32'd1);
    check("f1_last_flag", 32'(last0), 32'd1);
    check("f1_last_data", 32'(dat0), 32'(exp_q[NB - 1]));
    wait_drain();
    check_rx("f1", 1);

    // Preamble with one flipped bit: strict instance stays out, tolerant one locks.
    flipped = pre ^ 32'h0000_0020;
    send_word(32'h0000_1B35, 13);
    send_word(flipped >> 1, 31);
    check("me1_early", 32'(lock1), 32'd0);
    send_bit(flipped[0]);
    check("me0_nolock", 32'(lock0), 32'd0);
    check("me1_lock", 32'(lock1), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preamble pattern inside the payload must not re-sync.
    exp_q.delete();
    build_payload(2);
    exp_q[10] = 8'hCF;
    exp_q[11] = 8'h80;
    exp_q[12] = 8'hAA;
    exp_q[13] = 8'h31;
    rx_dat.delete();
    rx_last.delete();
    send_frame(0);
    check("embed_unlock", 32'(lock0), 32'd0);
    wait_drain();
    check_rx("embed", 1);

    // Output backpressure for 20 cycles starting at byte 3.
    exp_q.delete();
    build_payload(3);
    rx_dat.delete();
    rx_last.delete();
    fork
      send_frame(0);
      begin
        n = 0;
        found = 1'b0;
        while (n < 3000 && !found) begin
          @(posedge clk);
          #1;
          n++;
          if (vld0 && rx_dat.size() == 3) found = 1'b1;
        end
        check("bp_found", 32'(found), 32'd1);
        rdy_out = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("bp_ready_drop", 32'(rdy0), 32'd0);
        check("bp_hold_vld", 32'(vld0), 32'd1);
        check("bp_hold_data", 32'(dat0), 32'(exp_q[3]));
        repeat (8) @(posedge clk);
        #1;
        rdy_out = 1'b1;
      end
    join
    wait_drain();
    check_rx("bp", 1);

    // Reset at payload bit 100 with a byte pending.
    exp_q.delete();
    build_payload(4);
    send_word(pre, 32);
    for (int k = 0; k < 95; k++) send_pbit(k);
    rdy_out = 1'b0;
    for (int k = 95; k < 100; k++) send_pbit(k);
    check("mid_pending", 32'(vld0), 32'd1);
    check("mid_locked", 32'(lock0), 32'd1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 32'(vld0), 32'd0);
    check("mid_rst_last", 32'(last0), 32'd0);
    check("mid_rst_data", 32'(dat0), 32'd0);
    check("mid_rst_locked", 32'(lock0), 32'd0);
    check("mid_rst_ready", 32'(rdy0), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_out = 1'b1;
    @(posedge clk);
    #1;
    rx_dat.delete();
    rx_last.delete();
    send_frame(0);
    wait_drain();
    check_rx("post_rst", 1);

    // Two frames back to back.
    exp_q.delete();
    build_payload(5);
    build_payload(6);
    rx_dat.delete();
    rx_last.delete();
    send_frame(0);
    send_frame(NB);
    wait_drain();
    check_rx("b2b", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
